// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared constants and FSM encoding for the ADC frame capture block.
package adc_cap_pkg;

  localparam int unsigned ADC_CAP_DW    = 8;
  localparam int unsigned ADC_CAP_DEPTH = 256;
  localparam int unsigned ADC_CAP_AW    = $clog2(ADC_CAP_DEPTH);

  // Encodings are visible on the state output port, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_cap_ram.sv
// adc_cap_ram: DW x DEPTH simple dual-port RAM, one write port, one read port,
// synchronous write and registered read on a single clock (block-RAM style).
module adc_cap_ram
  import adc_cap_pkg::*;
#(
  parameter int unsigned DW    = ADC_CAP_DW,
  parameter int unsigned DEPTH = ADC_CAP_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk_i) begin
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: samples a parallel ADC bus, decimates it, waits for a
// rising threshold crossing or forced trigger once armed, captures DEPTH
// samples into a RAM and streams them out over valid/ready.
// Optional feature macro: ADC_CAP_PEAK_EN (frame min/max tracking).
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned DW    = ADC_CAP_DW,
  parameter int unsigned DEPTH = ADC_CAP_DEPTH
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [DW-1:0] adc_d,
  input  logic          arm,
  input  logic          force_i,
  input  logic [DW-1:0] trig_level,
  input  logic [7:0]    decim,
  output logic [DW-1:0] live,
  output logic          busy,
  output logic [1:0]    state,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic [DW-1:0] peak_max,
  output logic [DW-1:0] peak_min
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  cap_state_e    state_q, state_d;

  logic [DW-1:0] s0_q;
  logic [DW-1:0] prev_q, prev_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          tick;
  logic          crossing;
  logic          trig_fire;

  logic          pend_q, pend_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          fetched_all_q, fetched_all_d;
  logic          load;
  logic          hs;

  // ---------------------------------------------------------------------------
  // Sample stage: input register, decimator, previous-tick sample.
  // ---------------------------------------------------------------------------
  assign tick     = (dcnt_q == '0);
  assign dcnt_d   = tick ? decim : (dcnt_q - 8'd1);
  assign prev_d   = tick ? s0_q : prev_q;
  assign crossing = tick && (prev_q < trig_level) && (s0_q >= trig_level);
  assign live     = s0_q;

  // Input sample, decimation counter and previous-tick sample registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s0_q   <= '0;
      dcnt_q <= '0;
      prev_q <= '0;
    end else begin
      s0_q   <= adc_d;
      dcnt_q <= dcnt_d;
      prev_q <= prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arm)                               state_d = ST_ARMED;
      ST_ARMED:   if (trig_fire)                         state_d = ST_CAPTURE;
      ST_CAPTURE: if (ram_we && (wr_ptr_q == LAST_ADDR)) state_d = ST_READOUT;
      ST_READOUT: if (hs && rd_last_q)                   state_d = ST_IDLE;
      default:                                           state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: busy flag, trigger strobe and RAM write enable.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    trig_fire = 1'b0;
    ram_we    = 1'b0;
    unique case (state_q)
      ST_ARMED: begin
        trig_fire = tick && (crossing || pend_q);
        ram_we    = trig_fire;
      end
      ST_CAPTURE: ram_we = tick;
      default: ;
    endcase
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Capture bookkeeping
  // ---------------------------------------------------------------------------
  // Pending-force flag only lives in ARMED; it is consumed by the trigger.
  always_comb begin
    pend_d = 1'b0;
    if ((state_q == ST_ARMED) && !trig_fire) pend_d = pend_q || force_i;
  end

  // Write pointer sits at 0 outside a capture, so the trigger sample lands at index 0.
  assign wr_ptr_d = ram_we ? (wr_ptr_q + 1'b1)
                           : ((state_q == ST_CAPTURE) ? wr_ptr_q : '0);

  // ---------------------------------------------------------------------------
  // Readout: the RAM is addressed with the next pointer, so its registered
  // output always holds the word that the output register loads next. This
  // gives one word per clock without bubbles and holds steady under stall.
  // ---------------------------------------------------------------------------
  assign hs   = rd_valid_q && rd_ready;
  assign load = (state_q == ST_READOUT) && !fetched_all_q && (!rd_valid_q || rd_ready);

  // Output register and read pointer next-state.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    rd_last_d     = rd_last_q;
    fetched_all_d = fetched_all_q;
    if (trig_fire) begin
      rd_ptr_d      = '0;
      fetched_all_d = 1'b0;
    end else if (load) begin
      rd_data_d     = ram_rdata;
      rd_valid_d    = 1'b1;
      rd_last_d     = (rd_ptr_q == LAST_ADDR);
      fetched_all_d = (rd_ptr_q == LAST_ADDR);
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end else if (hs) begin
      rd_valid_d    = 1'b0;
      rd_last_d     = 1'b0;
    end
  end

  // Capture/readout bookkeeping registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      fetched_all_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      fetched_all_q <= fetched_all_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

  adc_cap_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s0_q),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Frame peak tracking
  // ---------------------------------------------------------------------------
`ifdef ADC_CAP_PEAK_EN
  logic [DW-1:0] peak_max_q, peak_max_d;
  logic [DW-1:0] peak_min_q, peak_min_d;

  // Trigger sample seeds both peaks; later capture writes widen them.
  always_comb begin
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    if (trig_fire) begin
      peak_max_d = s0_q;
      peak_min_d = s0_q;
    end else if (ram_we) begin
      if (s0_q > peak_max_q) peak_max_d = s0_q;
      if (s0_q < peak_min_q) peak_min_d = s0_q;
    end
  end

  // Peak registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      peak_max_q <= '0;
      peak_min_q <= '1;
    end else begin
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
    end
  end

  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;
`else
  assign peak_max = '0;
  assign peak_min = '1;
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed testbench for adc_frame_capture (DW=8, DEPTH=16).
module tb_adc_frame_capture;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] adc_d = 8'h00;
  logic       arm = 1'b0;
  logic       force_i = 1'b0;
  logic [7:0] trig_level = 8'h80;
  logic [7:0] decim = 8'd0;
  logic       rd_ready = 1'b0;
  logic [7:0] live, rd_data, peak_max, peak_min;
  logic       busy, rd_valid, rd_last;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  bit         ramp_en = 1'b0;
  logic [7:0] cap_w [32];
  logic       cap_l [32];
  int         cap_n;
  int         stall_bad;
  bit         tmo;
  logic [1:0] post_state;
  logic       post_valid;

  adc_frame_capture #(
    .DW    (8),
    .DEPTH (16)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .adc_d      (adc_d),
    .arm        (arm),
    .force_i    (force_i),
    .trig_level (trig_level),
    .decim      (decim),
    .live       (live),
    .busy       (busy),
    .state      (state),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .peak_max   (peak_max),
    .peak_min   (peak_min)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    if (ramp_en) adc_d = adc_d + 8'd1;
  endtask

  // Gathers one frame from the read port; stall stability violations are counted.
  task automatic collect(input bit toggle, input bit arm_on_last, input int budget);
    bit         holding;
    logic [7:0] hd;
    logic       hl;
    holding = 1'b0;
    hd = '0;
    hl = 1'b0;
    cap_n = 0;
    stall_bad = 0;
    tmo = 1'b1;
    post_state = 2'bxx;
    post_valid = 1'bx;
    for (int i = 0; i < 32; i++) begin
      cap_w[i] = 'x;
      cap_l[i] = 1'bx;
    end
    for (int c = 0; c < budget; c++) begin
      rd_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (holding) begin
        if (rd_valid !== 1'b1 || rd_data !== hd || rd_last !== hl) stall_bad++;
        holding = 1'b0;
      end
      if (rd_valid === 1'b1 && rd_ready) begin
        if (cap_n < 32) begin
          cap_w[cap_n] = rd_data;
          cap_l[cap_n] = rd_last;
        end
        cap_n++;
        if (rd_last === 1'b1) begin
          arm = arm_on_last;
          step();
          arm = 1'b0;
          post_state = state;
          post_valid = rd_valid;
          tmo = 1'b0;
          break;
        end
      end else if (rd_valid === 1'b1) begin
        holding = 1'b1;
        hd = rd_data;
        hl = rd_last;
      end
      step();
    end
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc_d = (i % 2 == 0) ? 8'h55 : 8'hAA;
      step();
    end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    n_tests++; if (rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", rd_last); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", rd_data); end
    n_tests++; if (live !== 8'h00) begin n_fail++; $display("FAIL rst_live: got %h want 00", live); end
    n_tests++; if (peak_min !== 8'hFF) begin n_fail++; $display("FAIL rst_pmin: got %h want ff", peak_min); end
    n_tests++; if (peak_max !== 8'h00) begin n_fail++; $display("FAIL rst_pmax: got %h want 00", peak_max); end
    adc_d = 8'h55;
    RESET_N = 1'b1;
    n_tests++; if (live !== 8'h00) begin n_fail++; $display("FAIL rst_live_release: got %h want 00", live); end
    step();
    n_tests++; if (live !== 8'h55) begin n_fail++; $display("FAIL rst_live_after: got %h want 55", live); end
  endtask

  task automatic test_threshold();
    ramp_en = 1'b0;
    adc_d = 8'h70;
    decim = 8'd0;
    trig_level = 8'h80;
    rd_ready = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL thr_armed: state got %0d want 1", state); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL thr_busy: got %b want 1", busy); end
    ramp_en = 1'b1;
    collect(1'b0, 1'b1, 200);
    ramp_en = 1'b0;
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL thr_timeout: no rd_last handshake in budget"); end
    n_tests++; if (cap_n !== 16) begin n_fail++; $display("FAIL thr_count: got %0d want 16", cap_n); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (cap_w[i] !== 8'(8'h80 + i) || cap_l[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL thr_word%0d: got %h last=%b want %h last=%b", i, cap_w[i], cap_l[i], 8'(8'h80 + i), (i == 15));
      end
    end
    n_tests++; if (post_state !== 2'd0) begin n_fail++; $display("FAIL thr_post_state: got %0d want 0", post_state); end
    n_tests++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL thr_post_valid: got %b want 0", post_valid); end
    step();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL thr_arm_ignored: state got %0d want 0", state); end
  endtask

  task automatic test_decimation();
    ramp_en = 1'b0;
    adc_d = 8'h70;
    decim = 8'd3;
    trig_level = 8'h80;
    arm = 1'b1;
    step();
    arm = 1'b0;
    ramp_en = 1'b1;
    collect(1'b0, 1'b0, 400);
    ramp_en = 1'b0;
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL dec_timeout: no rd_last handshake in budget"); end
    n_tests++; if (cap_n !== 16) begin n_fail++; $display("FAIL dec_count: got %0d want 16", cap_n); end
    n_tests++;
    if (!(cap_w[0] >= 8'h80 && cap_w[0] <= 8'h83)) begin
      n_fail++; $display("FAIL dec_first: got %h want 80..83", cap_w[0]);
    end
    for (int i = 1; i < 16; i++) begin
      n_tests++;
      if (8'(cap_w[i] - cap_w[i-1]) !== 8'd4 || cap_l[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL dec_step%0d: got %h after %h last=%b want +4 last=%b", i, cap_w[i], cap_w[i-1], cap_l[i], (i == 15));
      end
    end
    n_tests++; if (post_state !== 2'd0) begin n_fail++; $display("FAIL dec_post_state: got %0d want 0", post_state); end
    decim = 8'd0;
  endtask

  task automatic test_force_backpressure();
    ramp_en = 1'b0;
    adc_d = 8'h10;
    decim = 8'd0;
    trig_level = 8'h80;
    step();
    force_i = 1'b1;
    step();
    force_i = 1'b0;
    step();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL frc_idle_ignored: state got %0d want 0", state); end
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL frc_armed_hold: state got %0d want 1", state); end
    force_i = 1'b1;
    step();
    force_i = 1'b0;
    collect(1'b1, 1'b0, 200);
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL frc_timeout: no rd_last handshake in budget"); end
    n_tests++; if (cap_n !== 16) begin n_fail++; $display("FAIL frc_count: got %0d want 16", cap_n); end
    n_tests++; if (stall_bad !== 0) begin n_fail++; $display("FAIL frc_stall: %0d unstable stall cycles want 0", stall_bad); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (cap_w[i] !== 8'h10 || cap_l[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL frc_word%0d: got %h last=%b want 10 last=%b", i, cap_w[i], cap_l[i], (i == 15));
      end
    end
    n_tests++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL frc_post_valid: got %b want 0", post_valid); end
  endtask

  task automatic test_peaks();
    logic [7:0] exp_max, exp_min, want;
`ifdef ADC_CAP_PEAK_EN
    exp_max = 8'hFF;
    exp_min = 8'h00;
`else
    exp_max = 8'h00;
    exp_min = 8'hFF;
`endif
    ramp_en = 1'b0;
    adc_d = 8'h40;
    decim = 8'd0;
    rd_ready = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    force_i = 1'b1;
    step();
    force_i = 1'b0;
    step();
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL pk_capture: state got %0d want 2", state); end
    step();
    step();
    adc_d = 8'hFF;
    step();
    adc_d = 8'h40;
    step();
    step();
    adc_d = 8'h00;
    step();
    adc_d = 8'h40;
    collect(1'b0, 1'b0, 200);
    n_tests++; if (cap_n !== 16) begin n_fail++; $display("FAIL pk_count: got %0d want 16", cap_n); end
    for (int i = 0; i < 16; i++) begin
      want = (i == 4) ? 8'hFF : ((i == 7) ? 8'h00 : 8'h40);
      n_tests++;
      if (cap_w[i] !== want) begin
        n_fail++; $display("FAIL pk_word%0d: got %h want %h", i, cap_w[i], want);
      end
    end
    step();
    n_tests++; if (peak_max !== exp_max) begin n_fail++; $display("FAIL pk_max_idle: got %h want %h", peak_max, exp_max); end
    n_tests++; if (peak_min !== exp_min) begin n_fail++; $display("FAIL pk_min_idle: got %h want %h", peak_min, exp_min); end
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL pk_rearm: state got %0d want 1", state); end
    n_tests++; if (peak_max !== exp_max) begin n_fail++; $display("FAIL pk_max_armed: got %h want %h", peak_max, exp_max); end
    n_tests++; if (peak_min !== exp_min) begin n_fail++; $display("FAIL pk_min_armed: got %h want %h", peak_min, exp_min); end
  endtask

  task automatic test_reset_mid();
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    ramp_en = 1'b0;
    adc_d = 8'h22;
    decim = 8'd0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    force_i = 1'b1;
    step();
    force_i = 1'b0;
    step();
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL rm_capture: state got %0d want 2", state); end
    for (int i = 0; i < 4; i++) step();
    RESET_N = 1'b0;
    #1;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rm_state: got %0d want 0", state); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_tests++; if (peak_max !== 8'h00) begin n_fail++; $display("FAIL rm_pmax: got %h want 00", peak_max); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid%0d: got %b want 0", i, rd_valid); end
    end
    RESET_N = 1'b1;
    adc_d = 8'h70;
    trig_level = 8'h80;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    ramp_en = 1'b1;
    collect(1'b0, 1'b0, 200);
    ramp_en = 1'b0;
    n_tests++; if (cap_n !== 16) begin n_fail++; $display("FAIL rm_count: got %0d want 16", cap_n); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (cap_w[i] !== 8'(8'h80 + i) || cap_l[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL rm_word%0d: got %h last=%b want %h last=%b", i, cap_w[i], cap_l[i], 8'(8'h80 + i), (i == 15));
      end
    end
    n_tests++; if (post_state !== 2'd0) begin n_fail++; $display("FAIL rm_post_state: got %0d want 0", post_state); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_decimation();
    test_force_backpressure();
    test_peaks();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
